// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, funct3 codes, FSM states and legality check for the load/store unit
package lsu_pkg;
  localparam int XLEN = 32;
  localparam int DEPTH_WORDS = 512;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;
  function automatic logic f3_ok(input logic we, input logic [2:0] f3);
    return we ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response handshake plus word-addressed memory port of the load/store unit
interface lsu_if;
  import lsu_pkg::*;
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic rsp_valid, rsp_error;
  logic [XLEN-1:0] rsp_rdata;
  logic MemRead, MemWrite;
  logic [XLEN-1:0] address, WriteData, ReadData;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, MemRead, MemWrite, address, WriteData
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, MemRead, MemWrite, address, WriteData
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction with extension for loads, lane merge for subword stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] merged
);
  logic [4:0] sh;
  logic [15:0] lane;
  logic [XLEN-1:0] mask;
  assign sh = {offset, 3'b000};
  assign lane = 16'(word >> sh);
  assign mask = funct3[1:0] == 2'b00 ? XLEN'(32'hFF) : funct3[1:0] == 2'b01 ? XLEN'(32'hFFFF) : '1;
  always_comb
    rdata = funct3 == F3_B  ? {{(XLEN-8){lane[7]}}, lane[7:0]} :
            funct3 == F3_H  ? {{(XLEN-16){lane[15]}}, lane[15:0]} :
            funct3 == F3_BU ? {{(XLEN-8){1'b0}}, lane[7:0]} :
            funct3 == F3_HU ? {{(XLEN-16){1'b0}}, lane[15:0]} : word;
  assign merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV32 load/store engine with read-modify-write for subword stores
module load_store_unit
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);
  lsu_state_t state, next;
  logic we_q, accept, err;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [XLEN-1:0] wdata_q, idx, load_data, merged;
  assign idx = bus.req_addr >> 2;
  assign accept = bus.req_valid && state == IDLE;
  assign err = !f3_ok(bus.req_we, bus.req_funct3) ||
               (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
               (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
               idx >= XLEN'(DEPTH_WORDS);
  assign bus.req_ready = state == IDLE && !reset;
  always_comb
    next = state == IDLE ? (!accept ? IDLE : err ? RESP :
                            (bus.req_we && bus.req_funct3 == F3_W) ? WR : RD) :
           state == RD   ? (we_q ? WR : RESP) :
           state == WR   ? RESP : IDLE;
  lsu_lane_align u_align (
    .word   (bus.ReadData),
    .wdata  (wdata_q),
    .offset (off_q),
    .funct3 (f3_q),
    .rdata  (load_data),
    .merged (merged)
  );
  // Strobes are registered from next-state so they line up exactly with RD/WR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      wdata_q       <= '0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.address   <= '0;
      bus.WriteData <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      state         <= next;
      bus.MemRead   <= next == RD;
      bus.MemWrite  <= next == WR;
      bus.rsp_valid <= next == RESP;
      if (accept) begin
        we_q        <= bus.req_we;
        f3_q        <= bus.req_funct3;
        off_q       <= bus.req_addr[1:0];
        wdata_q     <= bus.req_wdata;
        bus.address <= idx;
      end
      if (state == IDLE && next == WR) bus.WriteData <= bus.req_wdata;
      if (state == RD && we_q) bus.WriteData <= merged;
      if (next == RESP) begin
        bus.rsp_error <= state == IDLE;
        bus.rsp_rdata <= state == RD ? load_data : '0;
      end
    end
  end
endmodule
